// File: rtl/tiled_mm_pkg.sv
// tiled_mm_pkg
//   Shared definitions for the tiled matrix-multiply controller:
//   FSM state encoding and elaboration-time helpers for the tile count K,
//   counter widths and BRAM address-range checks.
package tiled_mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_TILE = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_OUT       = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Number of BLOCK_SIZE tiles along the shared dimension.
    function automatic int unsigned calc_k(input int unsigned inner, input int unsigned bs);
        return inner / bs;
    endfunction

    // Width of a counter/coordinate able to hold 0..n-1 (never below 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when max_addr is representable in an unsigned field of 'width' bits.
    function automatic bit addr_fits(input longint unsigned max_addr, input int unsigned width);
        return max_addr < (64'd1 << width);
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// ctrl_delay_line
//   1-bit shift register of DEPTH stages; dout follows din exactly DEPTH
//   clock cycles later. Used to align the tile-start pulse with BRAM read data.
//   Ports: clk, rst (async active-high, clears all stages), din, dout.
module ctrl_delay_line #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/tiled_matmul_ctrl.sv
// tiled_matmul_ctrl
//   Sequencer for a tiled systolic matrix multiply. In IDLE/LOAD the host owns
//   the input and weight BRAM ports (pass-through); afterwards the controller
//   walks row-groups (rg), column-blocks (col) and inner tiles (k), issuing
//   BRAM reads, a delayed tile_start pulse, accumulator clears, and a
//   valid/ready handshake for each finished C block group.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     start, load_done            job control from host
//     in_wr_* / w_wr_*            host BRAM port controls
//     in_en/in_we/in_addr, w_*    muxed BRAM port controls
//     core_en, core_acc_clr,      core control
//     tile_start
//     core_tile_done,             core status
//     core_acc_done
//     out_valid/out_ready,        result handshake and C coordinates
//     out_row/out_col
//     busy, done                  job status
module tiled_matmul_ctrl
    import tiled_mm_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS    = 2,
    parameter int unsigned BLOCK_SIZE      = 4,
    parameter int unsigned INNER_DIMENSION = 16,
    parameter int unsigned ROW_BLOCKS      = 4,
    parameter int unsigned COL_BLOCKS      = 4,
    parameter int unsigned RD_LAT          = 2,
    parameter int unsigned ADDR_WIDTH_A    = 16,
    parameter int unsigned ADDR_WIDTH_B    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   load_done,
    input  logic [NUM_RD_PORTS-1:0]                in_wr_en,
    input  logic [NUM_RD_PORTS-1:0]                in_wr_we,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH_A-1:0]   in_wr_addr,
    input  logic                                   w_wr_en,
    input  logic                                   w_wr_we,
    input  logic [ADDR_WIDTH_B-1:0]                w_wr_addr,
    output logic [NUM_RD_PORTS-1:0]                in_en,
    output logic [NUM_RD_PORTS-1:0]                in_we,
    output logic [NUM_RD_PORTS*ADDR_WIDTH_A-1:0]   in_addr,
    output logic                                   w_en,
    output logic                                   w_we,
    output logic [ADDR_WIDTH_B-1:0]                w_addr,
    output logic                                   core_en,
    output logic                                   core_acc_clr,
    output logic                                   tile_start,
    input  logic                                   core_tile_done,
    input  logic                                   core_acc_done,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [cnt_width(ROW_BLOCKS)-1:0]       out_row,
    output logic [cnt_width(COL_BLOCKS)-1:0]       out_col,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned K       = calc_k(INNER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned RGROUPS = ROW_BLOCKS / NUM_RD_PORTS;
    localparam int unsigned K_W     = cnt_width(K);
    localparam int unsigned RG_W    = cnt_width(RGROUPS);
    localparam int unsigned COL_W   = cnt_width(COL_BLOCKS);
    localparam int unsigned ROW_W   = cnt_width(ROW_BLOCKS);

    if (INNER_DIMENSION % BLOCK_SIZE != 0) begin : g_err_inner
        $error("INNER_DIMENSION must be a multiple of BLOCK_SIZE");
    end
    if (ROW_BLOCKS % NUM_RD_PORTS != 0) begin : g_err_rows
        $error("ROW_BLOCKS must be a multiple of NUM_RD_PORTS");
    end
    if (RD_LAT < 1) begin : g_err_lat
        $error("RD_LAT must be at least 1");
    end
    if (!addr_fits(64'(K * ROW_BLOCKS - 1), ADDR_WIDTH_A)) begin : g_err_addr_a
        $error("input BRAM address range exceeds ADDR_WIDTH_A");
    end
    if (!addr_fits(64'(K * COL_BLOCKS - 1), ADDR_WIDTH_B)) begin : g_err_addr_b
        $error("weight BRAM address range exceeds ADDR_WIDTH_B");
    end

    state_t                              state;
    logic [K_W-1:0]                      k;
    logic [RG_W-1:0]                     rg;
    logic [COL_W-1:0]                    col;
    logic                                acc_done_q;
    logic                                acc_done_rise;
    logic [NUM_RD_PORTS*ADDR_WIDTH_A-1:0] in_addr_r;
    logic [ADDR_WIDTH_B-1:0]             w_addr_r;
    logic                                write_phase;

    assign acc_done_rise = core_acc_done && !acc_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            rg         <= '0;
            col        <= '0;
            acc_done_q <= 1'b0;
            in_addr_r  <= '0;
            w_addr_r   <= '0;
        end else begin
            acc_done_q <= core_acc_done;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        k     <= '0;
                        rg    <= '0;
                        col   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_done) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // Port p of row-group rg reads row-block rg*P+p; each row-block
                    // occupies K consecutive words.
                    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                        in_addr_r[p*ADDR_WIDTH_A +: ADDR_WIDTH_A] <=
                            ADDR_WIDTH_A'(32'(k) + K * (32'(rg) * NUM_RD_PORTS + p));
                    end
                    w_addr_r <= ADDR_WIDTH_B'(32'(k) + K * 32'(col));
                    state    <= ST_WAIT_TILE;
                end
                ST_WAIT_TILE: begin
                    if (core_tile_done) begin
                        if (k == K_W'(K - 1)) begin
                            k     <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            k     <= k + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (acc_done_rise) state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (col == COL_W'(COL_BLOCKS - 1)) begin
                            col <= '0;
                            if (rg == RG_W'(RGROUPS - 1)) begin
                                rg    <= '0;
                                state <= ST_DONE;
                            end else begin
                                rg    <= rg + 1'b1;
                                state <= ST_ISSUE;
                            end
                        end else begin
                            col   <= col + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ctrl_delay_line #(
        .DEPTH(RD_LAT)
    ) u_tile_start_dly (
        .clk (clk),
        .rst (rst),
        .din (state == ST_ISSUE),
        .dout(tile_start)
    );

    assign write_phase = (state == ST_IDLE) || (state == ST_LOAD);

    always_comb begin
        in_en        = in_wr_en;
        in_we        = in_wr_we;
        in_addr      = in_wr_addr;
        w_en         = w_wr_en;
        w_we         = w_wr_we;
        w_addr       = w_wr_addr;
        if (!write_phase) begin
            in_en   = '1;
            in_we   = '0;
            in_addr = in_addr_r;
            w_en    = 1'b1;
            w_we    = 1'b0;
            w_addr  = w_addr_r;
        end
        core_en      = (state == ST_ISSUE) || (state == ST_WAIT_TILE) ||
                       (state == ST_DRAIN) || (state == ST_OUT);
        core_acc_clr = (state == ST_ISSUE) && (k == '0);
        out_valid    = (state == ST_OUT);
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
        out_row      = ROW_W'(32'(rg) * NUM_RD_PORTS);
        out_col      = col;
    end

endmodule

// File: tb/tb_tiled_matmul_ctrl.sv
// tb_tiled_matmul_ctrl
//   Directed bench for tiled_matmul_ctrl with P=2, BLOCK_SIZE=2,
//   INNER_DIMENSION=4 (K=2), ROW_BLOCKS=4, COL_BLOCKS=3, RD_LAT=2.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   ctl bundle = {core_en, core_acc_clr, tile_start, out_valid, busy, done}.
module tb_tiled_matmul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_done;
    logic [1:0]  in_wr_en;
    logic [1:0]  in_wr_we;
    logic [31:0] in_wr_addr;
    logic        w_wr_en;
    logic        w_wr_we;
    logic [15:0] w_wr_addr;
    logic [1:0]  in_en;
    logic [1:0]  in_we;
    logic [31:0] in_addr;
    logic        w_en;
    logic        w_we;
    logic [15:0] w_addr;
    logic        core_en;
    logic        core_acc_clr;
    logic        tile_start;
    logic        core_tile_done;
    logic        core_acc_done;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        busy;
    logic        done;

    int vectors    = 0;
    int miscompares = 0;

    logic [5:0] ctl;
    assign ctl = {core_en, core_acc_clr, tile_start, out_valid, busy, done};

    tiled_matmul_ctrl #(
        .NUM_RD_PORTS   (2),
        .BLOCK_SIZE     (2),
        .INNER_DIMENSION(4),
        .ROW_BLOCKS     (4),
        .COL_BLOCKS     (3),
        .RD_LAT         (2),
        .ADDR_WIDTH_A   (16),
        .ADDR_WIDTH_B   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_done     (load_done),
        .in_wr_en      (in_wr_en),
        .in_wr_we      (in_wr_we),
        .in_wr_addr    (in_wr_addr),
        .w_wr_en       (w_wr_en),
        .w_wr_we       (w_wr_we),
        .w_wr_addr     (w_wr_addr),
        .in_en         (in_en),
        .in_we         (in_we),
        .in_addr       (in_addr),
        .w_en          (w_en),
        .w_we          (w_we),
        .w_addr        (w_addr),
        .core_en       (core_en),
        .core_acc_clr  (core_acc_clr),
        .tile_start    (tile_start),
        .core_tile_done(core_tile_done),
        .core_acc_done (core_acc_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row       (out_row),
        .out_col       (out_col),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        in_wr_en   = 2'b01;
        in_wr_we   = 2'b10;
        in_wr_addr = {16'h1234, 16'h0042};
        w_wr_en    = 1'b1;
        w_wr_we    = 1'b0;
        w_wr_addr  = 16'h00A5;
        #3;
        vectors++;
        if (ctl !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 000000", ctl);
        end
        vectors++;
        if ({out_row, out_col} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_coord: got row %0d col %0d want 0 0", out_row, out_col);
        end
        vectors++;
        if ({in_en, in_we, in_addr, w_en, w_we, w_addr} !==
            {2'b01, 2'b10, 16'h1234, 16'h0042, 1'b1, 1'b0, 16'h00A5}) begin
            miscompares++;
            $display("FAIL reset_passthru: got en %b we %b addr %h w %b%b %h", in_en, in_we, in_addr, w_en, w_we, w_addr);
        end
        @(negedge clk);
        rst        = 1'b0;
        in_wr_en   = '0;
        in_wr_we   = '0;
        in_wr_addr = '0;
        w_wr_en    = 1'b0;
        w_wr_addr  = '0;
    endtask

    // Leaves the DUT in LOAD.
    task automatic test_load_passthrough();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (ctl !== 6'b000010) begin
            miscompares++;
            $display("FAIL load_state: got %b want 000010", ctl);
        end
        in_wr_en   = 2'b11;
        in_wr_we   = 2'b11;
        in_wr_addr = {16'd5, 16'd4};
        w_wr_en    = 1'b1;
        w_wr_we    = 1'b1;
        w_wr_addr  = 16'd9;
        #1;
        vectors++;
        if (in_addr !== {16'd5, 16'd4} || in_we !== 2'b11 || in_en !== 2'b11) begin
            miscompares++;
            $display("FAIL load_in_port: got addr %h we %b en %b want 00050004 11 11", in_addr, in_we, in_en);
        end
        vectors++;
        if (w_addr !== 16'd9 || w_we !== 1'b1 || w_en !== 1'b1) begin
            miscompares++;
            $display("FAIL load_w_port: got addr %0d we %b en %b want 9 1 1", w_addr, w_we, w_en);
        end
        // start while in LOAD must not disturb anything
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        in_wr_en   = '0;
        in_wr_we   = '0;
        in_wr_addr = '0;
        w_wr_en    = 1'b0;
        w_wr_we    = 1'b0;
        w_wr_addr  = '0;
        vectors++;
        if (ctl !== 6'b000010) begin
            miscompares++;
            $display("FAIL load_hold: got %b want 000010", ctl);
        end
    endtask

    // Entered at the falling edge of the first ISSUE (k=0) cycle of the group;
    // returns at the falling edge of the cycle after the output transfer.
    task automatic run_group(input int rg, input int col, input int stall, input bit stray);
        logic [15:0] e_in0, e_in1, e_w;
        for (int kk = 0; kk < 2; kk++) begin
            vectors++;
            if (ctl !== {1'b1, (kk == 0), 4'b0010}) begin
                miscompares++;
                $display("FAIL issue_ctl rg%0d col%0d k%0d: got %b want %b", rg, col, kk, ctl, {1'b1, (kk == 0), 4'b0010});
            end
            if (stray && kk == 0) start = 1'b1;
            @(negedge clk);
            e_in0 = 16'(kk + 2 * (rg * 2));
            e_in1 = 16'(kk + 2 * (rg * 2 + 1));
            e_w   = 16'(kk + 2 * col);
            vectors++;
            if (in_addr !== {e_in1, e_in0} || w_addr !== e_w) begin
                miscompares++;
                $display("FAIL addr rg%0d col%0d k%0d: got in %0d,%0d w %0d want %0d,%0d w %0d",
                         rg, col, kk, in_addr[31:16], in_addr[15:0], w_addr, e_in1, e_in0, e_w);
            end
            vectors++;
            if ({in_en, in_we, w_en, w_we} !== 6'b110010 || ctl !== 6'b100010) begin
                miscompares++;
                $display("FAIL wait_ctl rg%0d col%0d k%0d: got port %b ctl %b want 110010 100010",
                         rg, col, kk, {in_en, in_we, w_en, w_we}, ctl);
            end
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (ctl !== 6'b101010) begin
                miscompares++;
                $display("FAIL tile_start rg%0d col%0d k%0d: got %b want 101010", rg, col, kk, ctl);
            end
            core_tile_done = 1'b1;
            @(negedge clk);
            core_tile_done = 1'b0;
        end
        vectors++;
        if (ctl !== 6'b100010) begin
            miscompares++;
            $display("FAIL drain_ctl rg%0d col%0d: got %b want 100010", rg, col, ctl);
        end
        if (stray) begin
            core_tile_done = 1'b1;
            @(negedge clk);
            core_tile_done = 1'b0;
            vectors++;
            if (ctl !== 6'b100010) begin
                miscompares++;
                $display("FAIL stray_drain rg%0d col%0d: got %b want 100010", rg, col, ctl);
            end
        end
        if (stall > 0) out_ready = 1'b0;
        core_acc_done = 1'b1;
        @(negedge clk);
        core_acc_done = 1'b0;
        for (int s = 0; s < ((stall > 0) ? stall : 1); s++) begin
            if (s > 0) @(negedge clk);
            vectors++;
            if (ctl !== 6'b100110 || out_row !== 2'(rg * 2) || out_col !== 2'(col)) begin
                miscompares++;
                $display("FAIL out cyc%0d: got ctl %b row %0d col %0d want 100110 row %0d col %0d",
                         s, ctl, out_row, out_col, rg * 2, col);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_job(input bit need_start, input int stall_group, input int stall_cycles,
                                 input int stray_group);
        if (need_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (ctl !== 6'b000010) begin
                miscompares++;
                $display("FAIL job_load: got %b want 000010", ctl);
            end
        end
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        for (int g = 0; g < 6; g++) begin
            run_group(g / 3, g % 3, (g == stall_group) ? stall_cycles : 0, g == stray_group);
        end
        vectors++;
        if (ctl !== 6'b000011) begin
            miscompares++;
            $display("FAIL done_pulse: got %b want 000011", ctl);
        end
        @(negedge clk);
        vectors++;
        if (ctl !== 6'b000000 || {out_row, out_col} !== 4'b0000) begin
            miscompares++;
            $display("FAIL back_to_idle: got ctl %b row %0d col %0d want 000000 0 0", ctl, out_row, out_col);
        end
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        run_group(0, 0, 0, 1'b0);
        // group (0,1): ISSUE, then WAIT_TILE until the tile_start cycle
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ctl !== 6'b101010 || out_col !== 2'd1) begin
            miscompares++;
            $display("FAIL pre_reset: got ctl %b col %0d want 101010 1", ctl, out_col);
        end
        #2;
        rst        = 1'b1;
        in_wr_en   = 2'b01;
        in_wr_we   = 2'b10;
        in_wr_addr = {16'd3, 16'd8};
        #1;
        vectors++;
        if (ctl !== 6'b000000 || {out_row, out_col} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_ctl: got ctl %b row %0d col %0d want 000000 0 0", ctl, out_row, out_col);
        end
        vectors++;
        if (in_en !== 2'b01 || in_we !== 2'b10 || in_addr !== {16'd3, 16'd8}) begin
            miscompares++;
            $display("FAIL mid_reset_ports: got en %b we %b addr %h want 01 10 00030008", in_en, in_we, in_addr);
        end
        @(negedge clk);
        rst        = 1'b0;
        in_wr_en   = '0;
        in_wr_we   = '0;
        in_wr_addr = '0;
        @(negedge clk);
        vectors++;
        if (ctl !== 6'b000000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b want 000000", ctl);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        load_done      = 1'b0;
        in_wr_en       = '0;
        in_wr_we       = '0;
        in_wr_addr     = '0;
        w_wr_en        = 1'b0;
        w_wr_we        = 1'b0;
        w_wr_addr      = '0;
        core_tile_done = 1'b0;
        core_acc_done  = 1'b0;
        out_ready      = 1'b1;

        test_reset();
        test_load_passthrough();
        test_full_job(1'b0, -1, 0, -1);
        test_full_job(1'b1, 4, 5, 2);
        test_reset_mid_job();
        test_full_job(1'b1, -1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
